// File: rtl/preadder_mt_pkg.sv
// Shared BN254 polynomial types and the coefficient-wise redundant add/subtract helper.
package preadder_mt_pkg;

    localparam int unsigned COEF_W = 16;
    localparam int unsigned N_COEF = 4;

    typedef logic [N_COEF-1:0][COEF_W-1:0] redundant_poly_L3;

    // Redundant form: each coefficient wraps independently, no carry or reduction between coefficients.
    function automatic redundant_poly_L3 poly_addsub(input redundant_poly_L3 a,
                                                     input redundant_poly_L3 b,
                                                     input logic sub);
        redundant_poly_L3 r;
        for (int unsigned i = 0; i < N_COEF; i++) begin
            r[i] = sub ? COEF_W'(a[i] - b[i]) : COEF_W'(a[i] + b[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/poly_adder_L3_L3.sv
// Pipelined redundant polynomial adder/subtractor with a fixed LATENCY of registered stages.
module poly_adder_L3_L3
    import preadder_mt_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  redundant_poly_L3 a,
    input  logic             b_sub,
    input  redundant_poly_L3 b,
    output redundant_poly_L3 z
);

    redundant_poly_L3 r_pipe [LATENCY];

    // Datapath only: validity is tracked by the caller, so no reset is needed here.
    always_ff @(posedge clk) begin
        r_pipe[0] <= poly_addsub(a, b, b_sub);
        for (int unsigned k = 1; k < LATENCY; k++) begin
            r_pipe[k] <= r_pipe[k-1];
        end
    end

    assign z = r_pipe[LATENCY-1];

endmodule

// File: rtl/preadder_mt.sv
// Multi-threaded pre-adder: combines operands with per-thread history X/Y, fixed latency ADD_LAT+1.
module preadder_mt
    import preadder_mt_pkg::*;
#(
    parameter int unsigned N_THREAD = 4,
    parameter int unsigned ADD_LAT  = 1,
    localparam int unsigned TW      = $clog2(N_THREAD)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    input  logic [TW-1:0]       in_thread,
    input  redundant_poly_L3    X,
    input  redundant_poly_L3    Y,
    input  logic [1:0]          mode1,
    input  logic [1:0]          mode2,
    input  logic [N_THREAD-1:0] clr,
    output logic                out_valid,
    output logic [TW-1:0]       out_thread,
    output redundant_poly_L3    Z0,
    output redundant_poly_L3    Z1,
    output logic                err
);

    localparam int unsigned LAST = ADD_LAT - 1;

    redundant_poly_L3    r_hx [N_THREAD];
    redundant_poly_L3    r_hy [N_THREAD];
    logic [N_THREAD-1:0] r_hv;

    logic             r_vld [ADD_LAT];
    logic [TW-1:0]    r_thr [ADD_LAT];
    logic [1:0]       r_m1  [ADD_LAT];
    logic [1:0]       r_m2  [ADD_LAT];
    logic             r_err [ADD_LAT];
    redundant_poly_L3 r_px  [ADD_LAT];
    redundant_poly_L3 r_py  [ADD_LAT];

    logic             w_hv;
    logic             w_err;
    redundant_poly_L3 w_hx;
    redundant_poly_L3 w_hy;
    redundant_poly_L3 w_xh;
    redundant_poly_L3 w_xy;
    redundant_poly_L3 w_yh;
    redundant_poly_L3 w_xmy;
    redundant_poly_L3 w_z0;
    redundant_poly_L3 w_z1;

    // History is read combinationally before the same-edge write, giving read-before-write.
    assign w_hv  = r_hv[in_thread];
    assign w_hx  = w_hv ? r_hx[in_thread] : '0;
    assign w_hy  = w_hv ? r_hy[in_thread] : '0;
    assign w_err = in_valid & ~w_hv & (mode1[0] | mode2[0]);

    poly_adder_L3_L3 #(.LATENCY(ADD_LAT)) u_add_xh (
        .clk(clk), .a(X), .b(w_hx), .b_sub(mode1[1]), .z(w_xh)
    );

    poly_adder_L3_L3 #(.LATENCY(ADD_LAT)) u_add_xy (
        .clk(clk), .a(X), .b(Y), .b_sub(1'b0), .z(w_xy)
    );

    poly_adder_L3_L3 #(.LATENCY(ADD_LAT)) u_add_yh (
        .clk(clk), .a(Y), .b(w_hy), .b_sub(mode2[1]), .z(w_yh)
    );

    poly_adder_L3_L3 #(.LATENCY(ADD_LAT)) u_sub_xy (
        .clk(clk), .a(X), .b(Y), .b_sub(1'b1), .z(w_xmy)
    );

    // Clear strobe first, then a same-cycle write to the thread re-validates it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hv <= '0;
        end else begin
            r_hv <= r_hv & ~clr;
            if (in_valid) begin
                r_hv[in_thread] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_hx[in_thread] <= X;
            r_hy[in_thread] <= Y;
        end
    end

    // Control pipeline runs alongside the adders so mode selects line up with their results.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < ADD_LAT; k++) begin
                r_vld[k] <= 1'b0;
                r_thr[k] <= '0;
                r_m1[k]  <= '0;
                r_m2[k]  <= '0;
                r_err[k] <= 1'b0;
            end
        end else begin
            r_vld[0] <= in_valid;
            r_thr[0] <= in_thread;
            r_m1[0]  <= mode1;
            r_m2[0]  <= mode2;
            r_err[0] <= w_err;
            for (int unsigned k = 1; k < ADD_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_thr[k] <= r_thr[k-1];
                r_m1[k]  <= r_m1[k-1];
                r_m2[k]  <= r_m2[k-1];
                r_err[k] <= r_err[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_px[0] <= X;
        r_py[0] <= Y;
        for (int unsigned k = 1; k < ADD_LAT; k++) begin
            r_px[k] <= r_px[k-1];
            r_py[k] <= r_py[k-1];
        end
    end

    always_comb begin
        w_z0 = r_px[LAST];
        w_z1 = r_py[LAST];
        case (r_m1[LAST])
            2'b01, 2'b11: w_z0 = w_xh;
            2'b10:        w_z0 = w_xy;
            default:      w_z0 = r_px[LAST];
        endcase
        case (r_m2[LAST])
            2'b01, 2'b11: w_z1 = w_yh;
            2'b10:        w_z1 = w_xmy;
            default:      w_z1 = r_py[LAST];
        endcase
    end

    // Results and thread hold between valid outputs; err is only meaningful with out_valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            err        <= 1'b0;
            out_thread <= '0;
            Z0         <= '0;
            Z1         <= '0;
        end else begin
            out_valid <= r_vld[LAST];
            err       <= r_vld[LAST] & r_err[LAST];
            if (r_vld[LAST]) begin
                out_thread <= r_thr[LAST];
                Z0         <= w_z0;
                Z1         <= w_z1;
            end
        end
    end

endmodule

// File: tb/tb_preadder_mt.sv
// Directed bench for preadder_mt: per-cycle checks against a queue of hand-computed expectations.
module tb_preadder_mt;
    import preadder_mt_pkg::*;

    localparam int unsigned NT = 4;
    localparam int unsigned AL = 1;
    localparam int         L   = AL + 1;

    typedef struct {
        int               due;
        logic [1:0]       th;
        redundant_poly_L3 z0;
        redundant_poly_L3 z1;
        logic             er;
    } exp_t;

    logic             clk;
    logic             rstn;
    logic             in_valid;
    logic [1:0]       in_thread;
    redundant_poly_L3 X;
    redundant_poly_L3 Y;
    logic [1:0]       mode1;
    logic [1:0]       mode2;
    logic [NT-1:0]    clr;
    logic             out_valid;
    logic [1:0]       out_thread;
    redundant_poly_L3 Z0;
    redundant_poly_L3 Z1;
    logic             err;

    int               errors = 0;
    int               checks = 0;
    int               cyc    = 0;
    exp_t             q[$];
    redundant_poly_L3 last_z0;

    preadder_mt #(.N_THREAD(NT), .ADD_LAT(AL)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_thread(in_thread),
        .X(X), .Y(Y), .mode1(mode1), .mode2(mode2), .clr(clr),
        .out_valid(out_valid), .out_thread(out_thread), .Z0(Z0), .Z1(Z1), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic redundant_poly_L3 mk(input int v);
        redundant_poly_L3 p;
        for (int i = 0; i < int'(N_COEF); i++) p[i] = COEF_W'(v);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_out_thread", 64'(out_thread), 64'd0);
        chk("rst_Z0", Z0, 64'd0);
        chk("rst_Z1", Z1, 64'd0);
    endtask

    // One clock: outputs must match the expectation due this cycle, or be idle.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("out_valid", 64'(out_valid), 64'd1);
            chk("out_thread", 64'(out_thread), 64'(e.th));
            chk("Z0", Z0, e.z0);
            chk("Z1", Z1, e.z1);
            chk("err", 64'(err), 64'(e.er));
            last_z0 = e.z0;
        end else begin
            chk("idle_out_valid", 64'(out_valid), 64'd0);
            chk("idle_err", 64'(err), 64'd0);
            chk("hold_Z0", Z0, last_z0);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [1:0] th, input int x, input int y,
                        input logic [1:0] m1, input logic [1:0] m2,
                        input int ez0, input int ez1, input logic eer);
        exp_t e;
        in_valid  = 1'b1;
        in_thread = th;
        X         = mk(x);
        Y         = mk(y);
        mode1     = m1;
        mode2     = m2;
        e.due = cyc + L;
        e.th  = th;
        e.z0  = mk(ez0);
        e.z1  = mk(ez1);
        e.er  = eer;
        q.push_back(e);
        tick();
        in_valid = 1'b0;
        clr      = '0;
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_thread = '0;
        X         = '0;
        Y         = '0;
        mode1     = '0;
        mode2     = '0;
        clr       = '0;
        last_z0   = '0;
        #12;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // pass-through on the first edge after release
        send(2'd0, 3, 1, 2'b00, 2'b00, 3, 1, 1'b0);
        // same-thread back-to-back uses the previous X/Y
        send(2'd1, 5, 2, 2'b00, 2'b00, 5, 2, 1'b0);
        send(2'd1, 7, 4, 2'b01, 2'b11, 12, 2, 1'b0);
        // history miss substitutes zero
        send(2'd2, 9, 0, 2'b01, 2'b00, 9, 0, 1'b1);
        // interleaved threads, continuous throughput
        send(2'd0, 6, 4, 2'b10, 2'b10, 10, 2, 1'b0);
        send(2'd1, 6, 4, 2'b10, 2'b10, 10, 2, 1'b0);
        send(2'd2, 6, 4, 2'b10, 2'b10, 10, 2, 1'b0);
        send(2'd3, 6, 4, 2'b10, 2'b10, 10, 2, 1'b0);
        // subtractions wrap per coefficient
        send(2'd0, 2, 5, 2'b11, 2'b10, -4, -3, 1'b0);
        send(2'd2, 0, 3, 2'b00, 2'b01, 0, 7, 1'b0);
        send(2'd2, 1, 1, 2'b00, 2'b11, 1, -2, 1'b0);
        idle(3);

        // clear coinciding with a write: write wins
        clr = 4'b0010;
        send(2'd1, 8, 3, 2'b00, 2'b00, 8, 3, 1'b0);
        // idle inputs with in_valid low must not touch history
        in_thread = 2'd1;
        X         = mk(99);
        Y         = mk(99);
        mode1     = 2'b01;
        mode2     = 2'b01;
        idle(2);
        send(2'd1, 1, 0, 2'b01, 2'b00, 9, 0, 1'b0);

        // clear alone invalidates thread 3
        clr = 4'b1000;
        idle(1);
        clr = '0;
        send(2'd3, 1, 2, 2'b01, 2'b01, 1, 2, 1'b1);
        idle(3);

        // reset with operations in flight
        send(2'd0, 1, 1, 2'b00, 2'b00, 1, 1, 1'b0);
        send(2'd1, 2, 2, 2'b00, 2'b00, 2, 2, 1'b0);
        in_valid  = 1'b1;
        in_thread = 2'd2;
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_outputs();
        q.delete();
        last_z0 = '0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rstn = 1'b1;
        idle(4);
        send(2'd0, 5, 0, 2'b01, 2'b00, 5, 0, 1'b1);
        idle(4);

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
